// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants and state encoding for the nibble-serial adder
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_adder_4bit.sv
// rtl/nibble_serial_adder_adder_4bit.sv - ripple-carry nibble adder
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - digit-serial wide adder, one nibble per cycle, LS nibble first
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                      cout,
  output logic                      zero,
  output logic                      busy
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t state, state_nxt;

  logic [IW-1:0]       idx;
  logic                carry_q;
  logic [W-1:0]        op_a_q, op_b_q;
  logic [IW+1:0]       sh;
  logic [W-1:0]        a_sh, b_sh, result_nxt;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                add_cout;
  logic                last;

  // Bit offset of the current nibble; shifts keep the select width-clean for any NIBBLES.
  assign sh   = {idx, 2'b00};
  assign a_sh = op_a_q >> sh;
  assign b_sh = op_b_q >> sh;
  assign last = (idx == LAST_IDX);

  adder_4bit u_adder (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (add_cout)
  );

  assign result_nxt = (result & ~(W'(4'hF) << sh)) | (W'(sum_nib) << sh);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      carry_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a_q  <= op_a;
            op_b_q  <= op_b;
            carry_q <= cin;
            idx     <= '0;
            result  <= '0;
          end
        end
        ST_RUN: begin
          result  <= result_nxt;
          carry_q <= add_cout;
          idx     <= last ? '0 : idx + IW'(1);
          if (last) begin
            cout      <= add_cout;
            zero      <= (result_nxt == '0);
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed bench with queue-based arithmetic model
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, cin, out_ready;
  logic [15:0] op_a, op_b;
  logic        in_ready, out_valid, cout, zero, busy;
  logic [15:0] result;

  logic        in_valid_1, cin_1, out_ready_1;
  logic [3:0]  op_a_1, op_b_1;
  logic        in_ready_1, out_valid_1, cout_1, zero_1, busy_1;
  logic [3:0]  result_1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .zero(zero), .busy(busy)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .op_a(op_a_1), .op_b(op_b_1), .cin(cin_1), .out_valid(out_valid_1),
    .out_ready(out_ready_1), .result(result_1), .cout(cout_1), .zero(zero_1), .busy(busy_1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: each accepted bundle yields the full-width sum, bit 16 being the carry out.
  always @(posedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {16'b0, cin});
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("model_empty", 32'd1, 32'd0);
      else begin
        check("model_result", result, exp_q[0][15:0]);
        check("model_cout", cout, exp_q[0][16]);
        check("model_zero", zero, exp_q[0][15:0] == 16'h0);
      end
    end
  end

  task automatic wait_ready;
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int acc, output int l);
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) check("done_timeout", 32'd0, 32'd1);
    l = cyc - acc;
  endtask

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic ci, output int l);
    int acc;
    op_a = a; op_b = b; cin = ci; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    check("run_busy", busy, 32'd1);
    check("run_in_ready", in_ready, 32'd0);
    wait_done(acc, l);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] er, input logic ec, input logic ez);
    int acc;
    int n = 0;
    op_a_1 = a; op_b_1 = b; cin_1 = ci; in_valid_1 = 1'b1;
    while (!in_ready_1 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    acc = cyc;
    in_valid_1 = 1'b0;
    n = 0;
    while (!out_valid_1 && n < 100) begin @(posedge clk); #1; n++; end
    check("n1_valid", out_valid_1, 32'd1);
    check("n1_latency", cyc - acc, 32'd1);
    check("n1_result", result_1, er);
    check("n1_cout", cout_1, ec);
    check("n1_zero", zero_1, ez);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; cin = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
    in_valid_1 = 1'b0; cin_1 = 1'b0; out_ready_1 = 1'b1; op_a_1 = '0; op_b_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_cout", cout, 32'd0);
    check("rst_zero", zero, 32'd0);
    check("rst_busy", busy, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 32'd1);

    run4(16'h1234, 16'h4321, 1'b0, lat);
    check("add1_latency", lat, 32'd4);
    check("add1_result", result, 32'h5555);
    check("add1_cout", cout, 32'd0);
    check("add1_zero", zero, 32'd0);
    @(posedge clk); #1;

    run4(16'hFFFF, 16'h0001, 1'b0, lat);
    check("ripple_result", result, 32'h0000);
    check("ripple_cout", cout, 32'd1);
    check("ripple_zero", zero, 32'd1);
    @(posedge clk); #1;

    run4(16'hFFFF, 16'h0000, 1'b1, lat);
    check("cin_result", result, 32'h0000);
    check("cin_cout", cout, 32'd1);
    check("cin_zero", zero, 32'd1);
    @(posedge clk); #1;

    run4(16'hABCD, 16'h9876, 1'b1, lat);
    check("mix_result", result, 32'h4444);
    check("mix_cout", cout, 32'd1);
    @(posedge clk); #1;

    // Backpressure, with the next bundle already waiting on the input.
    out_ready = 1'b0;
    op_a = 16'h00FF; op_b = 16'h0F0F; cin = 1'b0; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    lat = cyc;
    op_a = 16'h1111; op_b = 16'h2222;
    wait_done(lat, lat);
    check("bp_latency", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", out_valid, 32'd1);
      check("bp_in_ready", in_ready, 32'd0);
      check("bp_result", result, 32'h100E);
      check("bp_cout", cout, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_busy", busy, 32'd0);
    check("bp_release_in_ready", in_ready, 32'd1);
    check("bp_release_out_valid", out_valid, 32'd0);
    @(posedge clk); #1;
    check("bp_pending_accepted", busy, 32'd1);
    in_valid = 1'b0;
    wait_done(cyc, lat);
    check("bp_pending_result", result, 32'h3333);
    @(posedge clk); #1;

    // Reset two RUN cycles into an operation.
    op_a = 16'h8000; op_b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_run_busy", busy, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 32'd0);
    check("abort_out_valid", out_valid, 32'd0);
    check("abort_in_ready", in_ready, 32'd1);
    check("abort_result", result, 32'd0);
    run4(16'h0001, 16'h0002, 1'b0, lat);
    check("after_abort_latency", lat, 32'd4);
    check("after_abort_result", result, 32'h0003);
    check("after_abort_cout", cout, 32'd0);
    @(posedge clk); #1;

    run1(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1);
    run1(4'h5, 4'h6, 1'b1, 4'hC, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
